// File: rtl/ascon_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_permutation_ctrl
//
// Iterative ASCON p^a engine. Holds the 320-bit state x0..x4 and applies one
// complete round per clock: constant addition on x2, bit-sliced 5-bit S-box,
// then per-word linear diffusion. A round count of 6, 8 or 12 (anything
// 1..12; larger values clamp to 12, zero passes the state through) is taken
// with start.
//
// Handshake: start is sampled on a rising edge only while busy=0, i.e. in
// IDLE or in the DONE cycle, so a new job can follow a finished one with no
// gap. busy is high for exactly the cycles in which rounds are being applied.
// done is a single-cycle pulse marking the cycle in which x*_out holds the
// finished result; the outputs then stay put until the next accepted start.
// abort cancels a job in RUN (no done, partial state kept) and beats a
// simultaneous start.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          request a permutation (sampled while busy=0)
//   abort          synchronous cancel of the running permutation
//   rounds         requested round count a, sampled with start
//   x0_in..x4_in   initial state words, sampled with start
//   x0_out..x4_out state register contents
//   busy           permutation in progress
//   done           one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module ascon_permutation_ctrl #(
    parameter int MAX_ROUNDS = 12,
    parameter int RND_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RND_W-1:0] rounds,
    input  logic [63:0]      x0_in,
    input  logic [63:0]      x1_in,
    input  logic [63:0]      x2_in,
    input  logic [63:0]      x3_in,
    input  logic [63:0]      x4_in,
    output logic [63:0]      x0_out,
    output logic [63:0]      x1_out,
    output logic [63:0]      x2_out,
    output logic [63:0]      x3_out,
    output logic [63:0]      x4_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [RND_W-1:0] MAX_R  = RND_W'(MAX_ROUNDS);
    localparam logic [RND_W-1:0] LAST_R = RND_W'(MAX_ROUNDS - 1);

    logic [1:0]       state_q;
    logic [RND_W-1:0] rnd_q;
    logic [63:0]      s0_q, s1_q, s2_q, s3_q, s4_q;

    logic [RND_W-1:0] a_eff;
    logic [RND_W-1:0] r_first;
    logic [7:0]       rc;
    logic [63:0]      p0, p1, p2, p3, p4;
    logic [63:0]      q0, q1, q2, q3, q4;
    logic [63:0]      y0, y1, y2, y3, y4;
    logic [63:0]      n0, n1, n2, n3, n4;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (32'd64 - n));
    endfunction

    // A job of a rounds runs the last a rounds of p^12, so the round index
    // starts at 12-a; this keeps the constant sequence identical for p^6/p^8.
    assign a_eff   = (rounds > MAX_R) ? MAX_R : rounds;
    assign r_first = MAX_R - a_eff;

    assign rc = {4'd15 - rnd_q[3:0], rnd_q[3:0]};

    // Bit-sliced S-box: each expression acts on all 64 columns at once,
    // with the round constant folded into the first x2 step.
    assign p0 = s0_q ^ s4_q;
    assign p1 = s1_q;
    assign p2 = s2_q ^ {56'd0, rc} ^ s1_q;
    assign p3 = s3_q;
    assign p4 = s4_q ^ s3_q;

    assign q0 = p0 ^ (~p1 & p2);
    assign q1 = p1 ^ (~p2 & p3);
    assign q2 = p2 ^ (~p3 & p4);
    assign q3 = p3 ^ (~p4 & p0);
    assign q4 = p4 ^ (~p0 & p1);

    assign y0 = q0 ^ q4;
    assign y1 = q1 ^ q0;
    assign y2 = ~q2;
    assign y3 = q3 ^ q2;
    assign y4 = q4;

    // Linear diffusion layer.
    assign n0 = y0 ^ ror64(y0, 19) ^ ror64(y0, 28);
    assign n1 = y1 ^ ror64(y1, 61) ^ ror64(y1, 39);
    assign n2 = y2 ^ ror64(y2, 1)  ^ ror64(y2, 6);
    assign n3 = y3 ^ ror64(y3, 10) ^ ror64(y3, 17);
    assign n4 = y4 ^ ror64(y4, 7)  ^ ror64(y4, 41);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (abort) begin
                        // Partial state is deliberately kept visible.
                        state_q <= ST_IDLE;
                    end else begin
                        s0_q  <= n0;
                        s1_q  <= n1;
                        s2_q  <= n2;
                        s3_q  <= n3;
                        s4_q  <= n4;
                        rnd_q <= rnd_q + 1'b1;
                        if (rnd_q == LAST_R) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new job.
                    if (start && !abort) begin
                        s0_q    <= x0_in;
                        s1_q    <= x1_in;
                        s2_q    <= x2_in;
                        s3_q    <= x3_in;
                        s4_q    <= x4_in;
                        rnd_q   <= r_first;
                        state_q <= (a_eff == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign x0_out = s0_q;
    assign x1_out = s1_q;
    assign x2_out = s2_q;
    assign x3_out = s3_q;
    assign x4_out = s4_q;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_permutation_ctrl
//
// Bench for the ASCON permutation sequencer. A job-level model (remaining
// round count, next round index, table-driven S-box) predicts busy, done and
// the state after every rising edge; each cycle the DUT is compared against it
// at the falling edge. Finished results also go through an expected queue.
// Directed jobs cover latency, clamping, zero rounds, handshake abuse, abort
// and asynchronous reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_ascon_permutation_ctrl;

    localparam int W = 320;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // p^1 of the all-zero state, worked out by hand (constant 4B).
    localparam logic [W-1:0] P1_ZERO = {
        64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
        64'h12E580000000004B, 64'h0000000000000000
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic         start, abort;
    logic [3:0]   rounds;
    logic [W-1:0] din;
    logic [63:0]  x0_out, x1_out, x2_out, x3_out, x4_out;
    logic         busy, done;
    logic [W-1:0] dout;

    assign dout = {x0_out, x1_out, x2_out, x3_out, x4_out};

    ascon_permutation_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .rounds (rounds),
        .x0_in  (din[319:256]),
        .x1_in  (din[255:192]),
        .x2_in  (din[191:128]),
        .x3_in  (din[127:64]),
        .x4_in  (din[63:0]),
        .x0_out (x0_out),
        .x1_out (x1_out),
        .x2_out (x2_out),
        .x3_out (x3_out),
        .x4_out (x4_out),
        .busy   (busy),
        .done   (done)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [W-1:0] m_x    = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_idx  = 0;
    int           m_left = 0;

    function automatic logic [7:0] model_rc(input int r);
        return 8'(((15 - r) << 4) | r);
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [W-1:0] model_round(input logic [W-1:0] s, input int r);
        logic [63:0] w[5];
        logic [63:0] o[5];
        logic [4:0]  col;
        logic [4:0]  sb;
        for (int k = 0; k < 5; k++) w[k] = s[319 - 64*k -: 64];
        w[2] = w[2] ^ {56'd0, model_rc(r)};
        for (int i = 0; i < 64; i++) begin
            col = {w[0][i], w[1][i], w[2][i], w[3][i], w[4][i]};
            sb  = SBOX[col];
            o[0][i] = sb[4];
            o[1][i] = sb[3];
            o[2][i] = sb[2];
            o[3][i] = sb[1];
            o[4][i] = sb[0];
        end
        w[0] = o[0] ^ rot(o[0], 19) ^ rot(o[0], 28);
        w[1] = o[1] ^ rot(o[1], 61) ^ rot(o[1], 39);
        w[2] = o[2] ^ rot(o[2], 1)  ^ rot(o[2], 6);
        w[3] = o[3] ^ rot(o[3], 10) ^ rot(o[3], 17);
        w[4] = o[4] ^ rot(o[4], 7)  ^ rot(o[4], 41);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [W-1:0] model_perm(input logic [W-1:0] s, input int a);
        logic [W-1:0] t = s;
        for (int r = 12 - a; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    function automatic logic [W-1:0] rand320();
        logic [W-1:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_x    = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
        m_left = 0;
    endtask

    // Predicts the effect of the coming rising edge from the inputs now driven.
    task automatic model_step();
        int a;
        logic [W-1:0] nx;
        if (rst_n) begin
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                end else begin
                    nx     = model_round(m_x, m_idx);
                    m_x    = nx;
                    m_idx  = m_idx + 1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        exp_q.push_back(nx);
                    end
                end
            end else if (start && !abort) begin
                a      = (rounds > 12) ? 12 : int'(rounds);
                m_x    = din;
                m_idx  = 12 - a;
                m_left = a;
                if (a == 0) begin
                    m_done = 1'b1;
                    exp_q.push_back(din);
                end else begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                end
            end else begin
                m_done = 1'b0;
            end
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic check_bits(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, plus result scoreboard on done.
    task automatic compare();
        logic [W-1:0] e;
        n_checks++;
        if (busy !== m_busy || done !== m_done || dout !== m_x) begin
            n_errors++;
            $display("FAIL cycle @%0t: busy=%b done=%b x=%h expected busy=%b done=%b x=%h",
                     $time, busy, done, dout, m_busy, m_done, m_x);
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL result @%0t: done with no expected result, x=%h", $time, dout);
            end else begin
                e = exp_q.pop_front();
                check_bits("result", dout, e);
            end
        end
    endtask

    // One clock: predict the edge, move to the next falling edge, compare.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [3:0] rnd, input logic [W-1:0] d);
        start  = 1'b1;
        rounds = rnd;
        din    = d;
        tick();
        start  = 1'b0;
        rounds = 4'($urandom_range(0, 15));
        din    = rand320();
    endtask

    // cnt0 = cycles already elapsed since start was sampled.
    task automatic wait_done(input int cnt0, input int exp_lat, input string name);
        int cnt = cnt0;
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check_int(name, cnt, exp_lat);
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] d;

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        rounds = 4'd0;
        din    = '0;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_bits("reset_state", dout, '0);
        rst_n = 1'b1;
        tick();

        // Pin the model against hand-derived values.
        check_int("rc0", int'(model_rc(0)), 8'hF0);
        check_int("rc4", int'(model_rc(4)), 8'hB4);
        check_int("rc6", int'(model_rc(6)), 8'h96);
        check_int("rc11", int'(model_rc(11)), 8'h4B);
        check_bits("model_p1_zero", model_perm('0, 1), P1_ZERO);

        // Single round on zero state against the literal.
        start_job(4'd1, '0);
        wait_done(1, 2, "lat_r1");
        check_bits("p1_zero", dout, P1_ZERO);
        tick();

        // Standard round counts on zero state.
        start_job(4'd12, '0);
        wait_done(1, 13, "lat_r12");
        tick();
        start_job(4'd6, '0);
        wait_done(1, 7, "lat_r6");
        tick();
        start_job(4'd8, '0);
        wait_done(1, 9, "lat_r8");
        tick();

        // rounds=0 passes the state straight through.
        d = rand320();
        start_job(4'd0, d);
        wait_done(1, 1, "lat_r0");
        check_bits("r0_passthru", dout, d);
        tick();

        // rounds=15 clamps to 12.
        start_job(4'd15, '0);
        wait_done(1, 13, "lat_r15");
        check_bits("r15_eq_p12", dout, model_perm('0, 12));
        tick();

        // Start while busy is ignored; then back-to-back start in DONE.
        start_job(4'd12, rand320());
        tick();
        tick();
        tick();
        start  = 1'b1;
        rounds = 4'd2;
        din    = rand320();
        tick();
        start  = 1'b0;
        wait_done(5, 13, "lat_ignored_start");
        d = rand320();
        start_job(4'd8, d);
        wait_done(1, 9, "lat_back_to_back");
        check_bits("b2b_result", dout, model_perm(d, 8));
        tick();

        // Abort on the 3rd round, then a clean job.
        start_job(4'd12, rand320());
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_int("abort_busy", int'(busy), 0);
        repeat (16) tick();
        d = rand320();
        start_job(4'd12, d);
        wait_done(1, 13, "lat_after_abort");
        check_bits("after_abort_result", dout, model_perm(d, 12));
        tick();

        // Asynchronous reset during the 5th round.
        start_job(4'd12, rand320());
        repeat (4) tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_done", int'(done), 0);
        check_bits("midrst_state", dout, '0);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        repeat (20) tick();

        // Random phase.
        for (int i = 0; i < 800; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 15) == 0);
            rounds = 4'($urandom_range(0, 15));
            din    = rand320();
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (20) tick();

        check_int("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
